otter_branch_predictor: RTL and testbench
=========================================

Name: otter_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined OTTER core; replaces always-not-taken fetch plus flush-on-resolve.
- IF stage looks up fetch PC each cycle and gets a predicted next PC.
- EX stage reports resolved branches/jumps; block trains a direct-mapped BTB with saturating counters and flags mispredictions for flush/redirect.

Parameters:
- XLEN, 32, address/PC width.
- ENTRIES, 16, BTB entries; power of 2, >= 2. IDX_BITS = log2(ENTRIES).
- TAG_BITS, 8, partial tag width, taken from PC[2+IDX_BITS+TAG_BITS-1 : 2+IDX_BITS].
- CTR_BITS, 2, saturating counter width, >= 1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch lookup valid (deasserted during lw_stall).
- if_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  EX has a resolved control-flow instruction.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_is_jump  in  1  unconditional (JAL/JALR).
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target when taken.
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  XLEN  predicted target carried down the pipe.
- mispredict  out  1  flush request.
- redirect_pc  out  XLEN  correct next PC when mispredict=1.

Behaviour:
- Each entry holds valid, tag[TAG_BITS], target[XLEN], ctr[CTR_BITS]. Index = PC[2+IDX_BITS-1:2].
- Lookup (combinational):
  - hit = if_valid & valid[idx] & tag match & !RST.
  - pred_taken = hit & ctr[MSB].
  - pred_target = pred_taken ? target : if_pc+4 (XLEN wrap).
- Reset: all valid bits cleared in the single RST cycle; counters/targets don't-care.
- Reset outputs: pred_taken=0; pred_target=if_pc+4; mispredict=0 (forced while RST=1); redirect_pc=upd_pc+4.
- Misprediction (combinational):
  - mispredict = upd_valid & (upd_taken != upd_pred_taken | (upd_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Update (registered, visible to lookup the cycle after upd_valid):
  - Hit, conditional branch: ctr saturating increment if taken, decrement if not (no wrap at max/0). Target written only if taken.
  - Hit, jump: ctr forced to all-ones; target written.
  - Miss, taken (or jump): allocate/overwrite entry. valid=1, tag and target written. ctr = all-ones for a jump, else weakly-taken (1<<(CTR_BITS-1)).
  - Miss, not taken: no allocation.
- Same cycle lookup and update to the same index: lookup returns pre-update contents; no bypass.
- Latency: lookup 0 cycles; training 1 cycle.
- RST asserted with upd_valid: reset wins; no update.

Optional Feature:
- Macro BP_PERF_COUNTERS_EN.
- When defined: adds outputs perf_lookups[32] (increments per if_valid cycle), perf_updates[32] (per upd_valid) and perf_mispredicts[32] (per mispredict cycle). All wrap at 2^32, cleared by RST.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Cold lookup: RST 1 cycle, then if_pc=0x100 -> pred_taken=0, pred_target=0x104.
- Allocate: upd pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle lookup 0x100 -> pred_taken=1, pred_target=0x80 (ctr=10).
- Hysteresis/saturation: 2 more taken updates then 0x100 not-taken x3 -> predict taken after 1st not-taken, not-taken after 2nd and 3rd. ctr reaches 00 and stays there on a further not-taken update.
- Aliasing: after training 0x100, lookup 0x140 (same index 0, tag 0x05 vs 0x04) -> miss, pred_target=0x144. Taken update 0x140 -> 0x200, then lookup 0x100 -> miss.
- Wrong-target jump: JALR upd pc=0x20, pred_taken=1, pred_target=0x80, actual target=0x90 -> mispredict=1, redirect_pc=0x90. Next lookup 0x20 -> 0x90.
- Same-cycle collision and reset: lookup and update of 0x100 in the same cycle -> old prediction returned that cycle, new one the next. RST mid-sequence -> all lookups miss; perf counters read 0 with BP_PERF_COUNTERS_EN.

Source files
------------

// File: rtl/otter_branch_predictor.sv
// otter_branch_predictor: direct-mapped BTB with saturating counters for the OTTER fetch stage.
// Optional performance counters are enabled by defining BP_PERF_COUNTERS_EN.
`default_nettype none

module otter_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_updates,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO   = 2 + IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic [XLEN-1:0]     if_pc_plus4;
  logic [XLEN-1:0]     upd_pc_plus4;

  logic                wr_en;
  logic                tgt_wr;
  logic [CTR_BITS-1:0] ctr_d;

  // Bits outside index/tag fields are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{if_pc, upd_pc};

  assign lk_idx       = if_pc[TAG_LO-1:2];
  assign lk_tag       = if_pc[TAG_LO+TAG_BITS-1:TAG_LO];
  assign up_idx       = upd_pc[TAG_LO-1:2];
  assign up_tag       = upd_pc[TAG_LO+TAG_BITS-1:TAG_LO];
  assign if_pc_plus4  = if_pc + XLEN'(4);
  assign upd_pc_plus4 = upd_pc + XLEN'(4);

  // Lookup path: combinational, reads pre-update state (no bypass).
  assign lk_hit      = if_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag) & ~RST;
  assign pred_taken  = lk_hit & ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc_plus4;

  assign mispredict  = ~RST & upd_valid &
                       ((upd_taken != upd_pred_taken) |
                        (upd_taken & (upd_target != upd_pred_target)));
  assign redirect_pc = (~RST & upd_taken) ? upd_target : upd_pc_plus4;

  assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

  always_comb begin
    wr_en  = 1'b0;
    tgt_wr = 1'b0;
    ctr_d  = ctr_q[up_idx];
    if (upd_valid && !RST) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          ctr_d  = CTR_MAX;
          tgt_wr = 1'b1;
        end else if (upd_taken) begin
          ctr_d  = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + CTR_BITS'(1);
          tgt_wr = 1'b1;
        end else begin
          ctr_d  = (ctr_q[up_idx] == '0) ? '0 : ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken || upd_is_jump) begin
        wr_en  = 1'b1;
        tgt_wr = 1'b1;
        ctr_d  = upd_is_jump ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (wr_en) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[up_idx] <= up_tag;
      ctr_q[up_idx] <= ctr_d;
      if (tgt_wr) target_q[up_idx] <= upd_target;
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] perf_lookups_q;
  logic [31:0] perf_updates_q;
  logic [31:0] perf_mispredicts_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_lookups_q     <= '0;
      perf_updates_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      if (if_valid)   perf_lookups_q     <= perf_lookups_q + 32'd1;
      if (upd_valid)  perf_updates_q     <= perf_updates_q + 32'd1;
      if (mispredict) perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
    end
  end

  assign perf_lookups     = perf_lookups_q;
  assign perf_updates     = perf_updates_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_otter_branch_predictor.sv
// Directed, table-driven bench for otter_branch_predictor (default parameters).
`default_nettype none

module tb_otter_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_updates;
  logic [31:0] perf_mispredicts;
`endif

  otter_branch_predictor dut (
    .CLK(CLK), .RST(RST),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_PERF_COUNTERS_EN
    , .perf_lookups(perf_lookups), .perf_updates(perf_updates),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ifv;
    logic [31:0] ipc;
    logic        uv;
    logic [31:0] upc;
    logic        uj;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic rst, logic ifv, logic [31:0] ipc,
                              logic uv, logic [31:0] upc, logic uj, logic ut,
                              logic [31:0] utgt, logic upt, logic [31:0] uptgt,
                              logic e_pt, logic [31:0] e_ptgt,
                              logic e_mis, logic [31:0] e_red);
    vec_t v;
    v.rst = rst; v.ifv = ifv; v.ipc = ipc; v.uv = uv; v.upc = upc; v.uj = uj;
    v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
    v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mis = e_mis; v.e_red = e_red;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check the combinational outputs mid-phase;
  // the following rising edge commits any update.
  task automatic apply(input vec_t v, input int k);
    @(negedge CLK);
    RST = v.rst; if_valid = v.ifv; if_pc = v.ipc;
    upd_valid = v.uv; upd_pc = v.upc; upd_is_jump = v.uj; upd_taken = v.ut;
    upd_target = v.utgt; upd_pred_taken = v.upt; upd_pred_target = v.uptgt;
    #2;
    chk($sformatf("v%0d pred_taken", k),  {31'd0, pred_taken}, {31'd0, v.e_pt});
    chk($sformatf("v%0d pred_target", k), pred_target, v.e_ptgt);
    chk($sformatf("v%0d mispredict", k),  {31'd0, mispredict}, {31'd0, v.e_mis});
    chk($sformatf("v%0d redirect_pc", k), redirect_pc, v.e_red);
  endtask

  initial begin
    RST = 1'b1; if_valid = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;

    //          rst ifv ipc           uv upc    uj ut utgt    upt uptgt     e_pt e_ptgt     e_mis e_red
    vecs.push_back(mk(1, 1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h0,   0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(0, 1, 32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4));
    // aliasing on index 0
    vecs.push_back(mk(0, 1, 32'h140, 1, 32'h140, 0, 1, 32'h200, 0, 32'h144, 0, 32'h144, 1, 32'h200));
    vecs.push_back(mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4));
    vecs.push_back(mk(0, 1, 32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h4));
    // wrong-target JALR
    vecs.push_back(mk(0, 1, 32'h20,  1, 32'h20,  1, 1, 32'h90,  1, 32'h80,  0, 32'h24,  1, 32'h90));
    vecs.push_back(mk(0, 1, 32'h20,  1, 32'h20,  1, 1, 32'h90,  1, 32'h90,  1, 32'h90,  0, 32'h90));
    // not-taken miss does not allocate
    vecs.push_back(mk(0, 1, 32'h30,  1, 32'h30,  0, 0, 32'h0,   0, 32'h34,  0, 32'h34,  0, 32'h34));
    vecs.push_back(mk(0, 1, 32'h30,  0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h34,  0, 32'h4));
    vecs.push_back(mk(0, 0, 32'h20,  0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h24,  0, 32'h4));
    // same-cycle lookup/update collision, jump forcing all-ones, target write rules
    vecs.push_back(mk(0, 1, 32'h140, 1, 32'h140, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h144));
    vecs.push_back(mk(0, 1, 32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h144, 0, 32'h4));
    vecs.push_back(mk(0, 1, 32'h140, 1, 32'h140, 1, 1, 32'h300, 0, 32'h144, 0, 32'h144, 1, 32'h300));
    vecs.push_back(mk(0, 1, 32'h140, 1, 32'h140, 0, 0, 32'h0,   1, 32'h300, 1, 32'h300, 1, 32'h144));
    vecs.push_back(mk(0, 1, 32'h140, 1, 32'h140, 0, 1, 32'h400, 1, 32'h300, 1, 32'h300, 1, 32'h400));
    vecs.push_back(mk(0, 1, 32'h140, 1, 32'h140, 0, 0, 32'h999, 1, 32'h400, 1, 32'h400, 1, 32'h144));
    vecs.push_back(mk(0, 1, 32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h4));
    vecs.push_back(mk(0, 1, 32'h20,  0, 32'h10,  0, 1, 32'h500, 0, 32'h0,   1, 32'h90,  0, 32'h500));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));
    // reset mid-sequence with a taken update: reset wins, everything misses after
    vecs.push_back(mk(1, 1, 32'h20,  1, 32'h30,  0, 1, 32'h700, 0, 32'h34,  0, 32'h24,  0, 32'h34));

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

`ifdef BP_PERF_COUNTERS_EN
    @(negedge CLK);
    RST = 1'b0; if_valid = 1'b0; upd_valid = 1'b0;
    #2;
    chk("perf_lookups after reset", perf_lookups, 32'd0);
    chk("perf_updates after reset", perf_updates, 32'd0);
    chk("perf_mispredicts after reset", perf_mispredicts, 32'd0);
`endif

    apply(mk(0, 1, 32'h30,  0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h34,  0, 32'h4), 100);
    apply(mk(0, 1, 32'h20,  0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h24,  0, 32'h4), 101);
    apply(mk(0, 1, 32'h140, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h144, 0, 32'h4), 102);

`ifdef BP_PERF_COUNTERS_EN
    // three lookups, one update producing a mispredict
    apply(mk(0, 0, 32'h0, 1, 32'h40, 0, 1, 32'h88, 0, 32'h44, 0, 32'h4, 1, 32'h88), 103);
    @(negedge CLK);
    upd_valid = 1'b0;
    #2;
    chk("perf_lookups count", perf_lookups, 32'd3);
    chk("perf_updates count", perf_updates, 32'd1);
    chk("perf_mispredicts count", perf_mispredicts, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
